// File: rtl/firo_sampler_ctrl.sv
// Sequencing controller for a Fibonacci ring-oscillator entropy source:
// warm-up, divided sampling, word packing with valid/ready, and RCT health test.
module firo_sampler_ctrl #(
    parameter int WORD_W        = 32,
    parameter int WARMUP_CYCLES = 256,
    parameter int SAMPLE_DIV    = 4,
    parameter int RCT_LIMIT     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              osc_en,
    output logic              dff_en,
    input  logic              random_bit,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              health_fail,
    output logic              busy
);

    localparam int WARM_W = $clog2(WARMUP_CYCLES) + 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV) + 1;
    localparam int BIT_W  = $clog2(WORD_W) + 1;
    localparam int RCT_W  = $clog2(RCT_LIMIT) + 1;

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(WORD_W - 1);
    localparam logic [RCT_W-1:0]  RCT_TRIP  = RCT_W'(RCT_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_SAMPLE,
        S_FULL,
        S_FAULT
    } state_t;

    state_t            r_state;
    logic [WARM_W-1:0] r_warm;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bits;
    logic [RCT_W-1:0]  r_rct;
    logic              r_prev;
    logic              r_pend;
    logic              r_osc_en;
    logic              r_dff_en;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_fail;
    logic              r_busy;

    logic [RCT_W-1:0]  w_rct_next;
    logic              w_trip;
    logic              w_last;

    // r_rct == 0 marks the first capture of a run, so no separate flag is kept.
    always_comb begin
        w_rct_next = r_rct;
        if (r_rct == '0 || random_bit != r_prev) begin
            w_rct_next = RCT_W'(1);
        end else begin
            w_rct_next = r_rct + RCT_W'(1);
        end
    end

    assign w_trip = r_pend && (w_rct_next == RCT_TRIP);
    assign w_last = r_pend && (r_bits == BITS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_warm   <= '0;
            r_div    <= '0;
            r_bits   <= '0;
            r_rct    <= '0;
            r_prev   <= 1'b0;
            r_pend   <= 1'b0;
            r_osc_en <= 1'b0;
            r_dff_en <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_fail   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_dff_en <= 1'b0;
            r_pend   <= r_dff_en;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state  <= S_WARMUP;
                        r_osc_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_warm   <= '0;
                        r_bits   <= '0;
                        r_rct    <= '0;
                        r_data   <= '0;
                    end
                end
                S_WARMUP, S_SAMPLE, S_FULL: begin
                    if (!run) begin
                        // Abort wins over handshakes and pending captures.
                        r_state  <= S_IDLE;
                        r_osc_en <= 1'b0;
                        r_valid  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_pend   <= 1'b0;
                        r_data   <= '0;
                    end else if (r_state == S_WARMUP) begin
                        if (r_warm == WARM_LAST) begin
                            r_state  <= S_SAMPLE;
                            r_dff_en <= 1'b1;
                            r_div    <= '0;
                        end else begin
                            r_warm <= r_warm + WARM_W'(1);
                        end
                    end else if (r_state == S_SAMPLE) begin
                        if (r_pend) begin
                            r_data <= {r_data[WORD_W-2:0], random_bit};
                            r_prev <= random_bit;
                            r_rct  <= w_rct_next;
                            r_bits <= r_bits + BIT_W'(1);
                        end
                        if (w_trip) begin
                            r_state  <= S_FAULT;
                            r_osc_en <= 1'b0;
                            r_fail   <= 1'b1;
                            r_data   <= '0;
                        end else if (w_last) begin
                            r_state <= S_FULL;
                            r_valid <= 1'b1;
                        end else if (r_div == DIV_LAST) begin
                            r_dff_en <= 1'b1;
                            r_div    <= '0;
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end else if (rnd_ready) begin
                        r_state  <= S_SAMPLE;
                        r_valid  <= 1'b0;
                        r_bits   <= '0;
                        r_dff_en <= 1'b1;
                        r_div    <= '0;
                    end
                end
                S_FAULT: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_fail  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_osc_en <= 1'b0;
                    r_valid  <= 1'b0;
                    r_fail   <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign osc_en      = r_osc_en;
    assign dff_en      = r_dff_en;
    assign rnd_data    = r_data;
    assign rnd_valid   = r_valid;
    assign health_fail = r_fail;
    assign busy        = r_busy;

endmodule

// File: doc/firo_sampler_ctrl.md
Name: firo_sampler_ctrl

Overview:
- Sequencing controller for one Fibonacci ring-oscillator entropy source (osc enable input, sample-enable input, registered XOR-combined random bit output).
- Gates the oscillator, waits a warm-up period, then pulses the source's sample enable at a fixed divider rate.
- Packs the returned bits into WORD_W-bit words and delivers them over a valid/ready handshake.
- Runs a repetition-count health test on the raw bits and latches a fault that stops the source.

Parameters:
- WORD_W, 32: output word width in bits (>= 2).
- WARMUP_CYCLES, 256: clock cycles that osc_en is high before the first sample pulse (>= 1).
- SAMPLE_DIV, 4: clock cycles between consecutive dff_en pulses (>= 2).
- RCT_LIMIT, 16: number of consecutive identical raw bits that declares a health failure (>= 2).

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- run, input, 1: level request; high means produce entropy, low means stop.
- osc_en, output, 1: drives the source's oscillator enable.
- dff_en, output, 1: drives the source's sample enable, as one-cycle pulses.
- random_bit, input, 1: registered output of the source; valid one cycle after a dff_en pulse.
- rnd_data, output, WORD_W: packed word.
- rnd_valid, output, 1: rnd_data holds a complete word.
- rnd_ready, input, 1: consumer accepts the word.
- health_fail, output, 1: sticky repetition-count failure.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all outputs 0, rnd_data = 0.
  - All counters cleared.
- States: IDLE, WARMUP, SAMPLE, FULL, FAULT. All outputs are registered.
- IDLE:
  - osc_en = 0, dff_en = 0.
  - If run is high at an edge, go to WARMUP: clear the warm-up counter, bit counter, RCT counter and rnd_data.
- WARMUP:
  - osc_en = 1.
  - After exactly WARMUP_CYCLES cycles in WARMUP, go to SAMPLE.
- SAMPLE:
  - osc_en = 1.
  - dff_en pulses high for one cycle in the first SAMPLE cycle, then every SAMPLE_DIV cycles.
  - In the cycle after each pulse, random_bit is captured: rnd_data <= {rnd_data[WORD_W-2:0], random_bit}, so the first captured bit ends in the MSB.
  - After the WORD_W-th capture, go to FULL with rnd_valid = 1 in the following cycle.
- FULL:
  - osc_en = 1, dff_en = 0 (sampling pauses).
  - rnd_valid and rnd_data are held stable until rnd_valid && rnd_ready at an edge.
  - On that handshake: rnd_valid = 0, bit counter cleared, return to SAMPLE. The next dff_en pulse occurs in the first cycle after the handshake.
- Timing example (cycle 0 = the edge at which run is sampled high in IDLE, defaults):
  - osc_en high at cycles 1..
  - dff_en pulses at cycles 257 + 4k, k = 0..31.
  - Captures at 258 + 4k.
  - rnd_valid first high at cycle 383.
- Repetition-count test (RCT):
  - Runs on every captured bit.
  - The counter is set to 1 on the first capture after WARMUP and whenever a bit differs from the previous bit; it increments on a repeated bit.
  - The counter persists across word boundaries within a run.
  - When the counter reaches RCT_LIMIT, go to FAULT in the next cycle. Any partial or full word is discarded.
- FAULT:
  - osc_en = 0, dff_en = 0, rnd_valid = 0, health_fail = 1.
  - Held until run is low, then IDLE; health_fail clears on leaving FAULT.
- run low in WARMUP, SAMPLE or FULL:
  - Next state IDLE; osc_en and dff_en go to 0 the next cycle.
  - rnd_valid drops and the word is discarded, even if unacknowledged; abort takes priority over a coincident handshake.
  - A capture pending from a pulse in the last cycle is dropped.
- rnd_ready is ignored when rnd_valid = 0.
- A handshake in the same edge as the RCT trip: the word is considered delivered, and the FSM still goes to FAULT.
- Counter widths: clog2 of the respective parameter + 1. No wrap is reachable in legal operation.

Test Plan:
- Reset/idle: rst_n low mid-SAMPLE -> all outputs 0 immediately (asynchronously); with run = 0 after release, osc_en stays 0 for 100 cycles.
- Nominal word, defaults, source model returning the pattern 1,0,1,1,... repeating from a shift register seeded 0xB5A3_96C1, bits MSB first -> dff_en pulses at 257 + 4k; rnd_valid at cycle 383 with rnd_data = 0xB5A3_96C1; osc_en high from cycle 1.
- Backpressure: rnd_ready held low 50 cycles after valid -> rnd_data and rnd_valid stable and no dff_en pulses; rnd_ready = 1 -> valid drops next cycle and a dff_en pulse occurs in that same cycle.
- Health fault: source stuck at 1 -> health_fail rises 1 cycle after the 16th capture, osc_en = 0, rnd_valid never asserted; run low -> IDLE, health_fail = 0; run high again -> warm-up restarts.
- RCT boundary: 15 ones, a zero, then 15 zeros across a word boundary -> no fault, two words delivered.
- Abort: run dropped during FULL with rnd_ready = 1 in the same cycle -> rnd_valid = 0 next cycle, state IDLE, osc_en = 0, busy = 0; the word is not counted as delivered.
